// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode encodings, FSM state type and opcode helpers for alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SHL   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SHR   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;
    localparam logic [3:0] ALU_MULHU = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_SLTU  = 4'b1011;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_REMU  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) ||
               (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    // Selects the upper accumulator half: MULHU high word, REMU remainder.
    function automatic logic wants_high(input logic [3:0] op);
        return (op == ALU_MULHU) || (op == ALU_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Purpose  : Request/response handshake bundle between the pipeline and alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             sign_flag;
    logic             carry_flag;
    logic             ovf_flag;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero_flag, sign_flag, carry_flag, ovf_flag
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero_flag, sign_flag, carry_flag, ovf_flag
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_iter
// Purpose  : One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             want_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand_b;
    logic               r_is_div;
    logic               r_want_hi;

    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;

    // Multiply: acc = {partial, multiplier}, add into the top half then shift right.
    // Divide:   acc = {remainder, dividend/quotient}, shift left then trial-subtract.
    always_comb begin
        w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_operand_b};
        w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, r_operand_b};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else if (r_acc[0]) begin
            w_acc_next = {w_add, r_acc[WIDTH-1:1]};
        end else begin
            w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    // The final step's outcome is offered combinationally so the owner can
    // register it on the same edge the step completes.
    assign done   = (r_count == CW'(1));
    assign result = r_want_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_acc       <= '0;
            r_operand_b <= '0;
            r_is_div    <= 1'b0;
            r_want_hi   <= 1'b0;
        end else if (start) begin
            r_count     <= CW'(WIDTH);
            r_acc       <= {{WIDTH{1'b0}}, a};
            r_operand_b <= b;
            r_is_div    <= is_div;
            r_want_hi   <= want_hi;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
            r_acc   <= w_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked integer ALU with flags and iterative unsigned mul/div.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    alu_state_e       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_sign;
    logic             r_carry;
    logic             r_ovf;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_div_zero;
    logic             w_start_iter;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_result;

    always_comb begin
        w_sum   = {1'b0, bus.src_a} + {1'b0, bus.src_b};
        w_diff  = {1'b0, bus.src_a} - {1'b0, bus.src_b};
        w_shamt = bus.src_b[SHW-1:0];
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                // No borrow out of the extended subtraction means A >= B.
                w_res   = w_diff[WIDTH-1:0];
                w_carry = ~w_diff[WIDTH];
                w_ovf   = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            ALU_SHL:  w_res = bus.src_a << w_shamt;
            ALU_SHR:  w_res = bus.src_a >> w_shamt;
            ALU_SRA:  w_res = $unsigned($signed(bus.src_a) >>> w_shamt);
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
            ALU_XOR:  w_res = bus.src_a ^ bus.src_b;
            ALU_OR:   w_res = bus.src_a | bus.src_b;
            ALU_AND:  w_res = bus.src_a & bus.src_b;
            // Only reached on divide-by-zero; nonzero divisors take the iterative path.
            ALU_DIVU: w_res = '1;
            ALU_REMU: w_res = bus.src_a;
            default:  w_res = '0;
        endcase
    end

    assign w_div_zero   = is_divide(bus.op) && (bus.src_b == '0);
    assign w_start_iter = (r_state == IDLE) && bus.in_valid &&
                          is_iterative(bus.op) && !w_div_zero;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start_iter),
        .is_div  (is_divide(bus.op)),
        .want_hi (wants_high(bus.op)),
        .a       (bus.src_a),
        .b       (bus.src_b),
        .done    (w_iter_done),
        .result  (w_iter_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_sign      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_start_iter) begin
                            r_state <= BUSY;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_sign      <= w_res[WIDTH-1];
                            r_carry     <= w_carry;
                            r_ovf       <= w_ovf;
                        end
                    end
                end
                BUSY: begin
                    if (w_iter_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_iter_result;
                        r_zero      <= (w_iter_result == '0);
                        r_sign      <= w_iter_result[WIDTH-1];
                        r_carry     <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.zero_flag  = r_zero;
    assign bus.sign_flag  = r_sign;
    assign bus.carry_flag = r_carry;
    assign bus.ovf_flag   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq: vector table, scoreboard, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq #(
    parameter int WIDTH = 32
);
    localparam logic [3:0] T_ADD = 4'b0000, T_SHL = 4'b0001, T_SUB = 4'b0010, T_SLT = 4'b0011;
    localparam logic [3:0] T_XOR = 4'b0100, T_SHR = 4'b0101, T_OR = 4'b0110, T_AND = 4'b0111;
    localparam logic [3:0] T_MUL = 4'b1000, T_MULHU = 4'b1001, T_DIVU = 4'b1010, T_SLTU = 4'b1011;
    localparam logic [3:0] T_SRA = 4'b1101, T_REMU = 4'b1110, T_U0 = 4'b1100, T_U1 = 4'b1111;

    localparam logic [WIDTH-1:0] ALL  = '1;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAXP = ~MINV;
    localparam int               LI   = WIDTH + 1;

    // flg packs {zero, sign, carry, ovf}
    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic [3:0]       flg;
        int               lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();
    alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [3:0] flags;
    assign flags = {bus.zero_flag, bus.sign_flag, bus.carry_flag, bus.ovf_flag};

    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;
    vec_t sb[$];
    vec_t tbl[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res,
                                input logic [3:0] flg, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat;
        return v;
    endfunction

    // Behavioural reference used for the randomised vectors.
    function automatic vec_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        vec_t                     v;
        logic [WIDTH:0]           s;
        logic signed [WIDTH:0]    se;
        logic [2*WIDTH-1:0]       p;
        logic signed [WIDTH-1:0]  sa;
        int                       sh;
        logic                     c;
        logic                     o;
        v.op = op; v.a = a; v.b = b; v.res = '0; c = 1'b0; o = 1'b0;
        sh = int'(b % WIDTH);
        sa = a;
        p  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            T_ADD: begin
                s = {1'b0, a} + {1'b0, b}; v.res = s[WIDTH-1:0]; c = s[WIDTH];
                se = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
                o = se[WIDTH] != se[WIDTH-1];
            end
            T_SUB: begin
                v.res = a - b; c = (a >= b);
                se = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
                o = se[WIDTH] != se[WIDTH-1];
            end
            T_SHL:   v.res = a << sh;
            T_SHR:   v.res = a >> sh;
            T_SRA:   v.res = sa >>> sh;
            T_SLT:   v.res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            T_SLTU:  v.res = (a < b) ? WIDTH'(1) : '0;
            T_XOR:   v.res = a ^ b;
            T_OR:    v.res = a | b;
            T_AND:   v.res = a & b;
            T_MUL:   v.res = p[WIDTH-1:0];
            T_MULHU: v.res = p[2*WIDTH-1:WIDTH];
            T_DIVU:  v.res = (b == '0) ? ALL : a / b;
            T_REMU:  v.res = (b == '0) ? a : a % b;
            default: v.res = '0;
        endcase
        v.flg = {v.res == '0, v.res[WIDTH-1], c, o};
        if (op == T_MUL || op == T_MULHU || ((op == T_DIVU || op == T_REMU) && b != '0))
            v.lat = LI;
        else
            v.lat = 1;
        return v;
    endfunction

    // Offer one op, push its expectation, wait for the result and compare.
    task automatic run_op(input vec_t v, input int hold);
        vec_t             e;
        int               cyc;
        int               busy_rdy;
        int               unstable;
        logic [WIDTH-1:0] snap_r;
        logic [3:0]       snap_f;
        n_vec++;
        bus.op = v.op; bus.src_a = v.a; bus.src_b = v.b;
        bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("accept_timeout", 64'(cyc < 200), 64'd1);
        sb.push_back(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom); bus.src_a = rnd(); bus.src_b = rnd();
        cyc = 1; busy_rdy = 0;
        while (bus.out_valid !== 1'b1 && cyc < 4 * WIDTH) begin
            if (bus.in_ready !== 1'b0) busy_rdy++;
            bus.in_valid = 1'($urandom);
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b0;
        check("busy_in_ready", 64'(busy_rdy), 64'd0);
        check("latency", 64'(cyc), 64'(v.lat));
        check("done_in_ready", 64'(bus.in_ready), 64'd0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("result op=%b", e.op), 64'(bus.result), 64'(e.res));
            check($sformatf("flags op=%b", e.op), 64'(flags), 64'(e.flg));
        end
        if (hold > 0) begin
            snap_r = bus.result; snap_f = flags; unstable = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (bus.result !== snap_r || flags !== snap_f ||
                    bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) unstable++;
            end
            check("hold_stable", 64'(unstable), 64'd0);
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("release_out_valid", 64'(bus.out_valid), 64'd0);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic reset_mid_busy();
        int n_ov;
        check("pre_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.op = T_DIVU; bus.src_a = WIDTH'(100); bus.src_b = WIDTH'(7);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(T_DIVU, WIDTH'(100), WIDTH'(7)));
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_flags", 64'(flags), 64'b1000);
        n_ov = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) n_ov++;
        end
        check("no_output_after_abort", 64'(n_ov), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]       rops[14];
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_flags", 64'(flags), 64'b1000);
        rst = 1'b0;

        tbl[0]  = mk(T_ADD,   MAXP,            WIDTH'(1),     MINV,           4'b0101, 1);
        tbl[1]  = mk(T_SUB,   WIDTH'(5),       WIDTH'(5),     '0,             4'b1010, 1);
        tbl[2]  = mk(T_SRA,   MINV,            WIDTH'('h24),  ~(ALL >> 5),    4'b0100, 1);
        tbl[3]  = mk(T_SHR,   MINV,            WIDTH'('h24),  MINV >> 4,      4'b0000, 1);
        tbl[4]  = mk(T_SLT,   ALL,             WIDTH'(1),     WIDTH'(1),      4'b0000, 1);
        tbl[5]  = mk(T_SLTU,  ALL,             WIDTH'(1),     '0,             4'b1000, 1);
        tbl[6]  = mk(T_MUL,   ALL,             WIDTH'(2),     ALL << 1,       4'b0100, LI);
        tbl[7]  = mk(T_MULHU, ALL,             WIDTH'(2),     WIDTH'(1),      4'b0000, LI);
        tbl[8]  = mk(T_DIVU,  WIDTH'(100),     WIDTH'(7),     WIDTH'(14),     4'b0000, LI);
        tbl[9]  = mk(T_REMU,  WIDTH'(100),     WIDTH'(7),     WIDTH'(2),      4'b0000, LI);
        tbl[10] = mk(T_DIVU,  WIDTH'('h1234),  '0,            ALL,            4'b0100, 1);
        tbl[11] = mk(T_REMU,  WIDTH'(9),       '0,            WIDTH'(9),      4'b0000, 1);
        tbl[12] = mk(T_ADD,   ALL,             WIDTH'(1),     '0,             4'b1010, 1);
        tbl[13] = mk(T_SUB,   '0,              WIDTH'(1),     ALL,            4'b0100, 1);
        tbl[14] = mk(T_SUB,   MINV,            WIDTH'(1),     MAXP,           4'b0011, 1);
        tbl[15] = mk(T_XOR,   WIDTH'('hF0),    WIDTH'('h3C),  WIDTH'('hCC),   4'b0000, 1);
        tbl[16] = mk(T_OR,    WIDTH'('hF0),    WIDTH'('h0F),  WIDTH'('hFF),   4'b0000, 1);
        tbl[17] = mk(T_AND,   WIDTH'('hF0),    WIDTH'('h3C),  WIDTH'('h30),   4'b0000, 1);
        tbl[18] = mk(T_SHL,   WIDTH'(3),       WIDTH'('h21),  WIDTH'(6),      4'b0000, 1);
        tbl[19] = mk(T_U0,    WIDTH'(5),       WIDTH'(3),     '0,             4'b1000, 1);
        tbl[20] = mk(T_U1,    WIDTH'(5),       WIDTH'(3),     '0,             4'b1000, 1);
        tbl[21] = mk(T_MUL,   WIDTH'(300),     WIDTH'(5),     WIDTH'(1500),   4'b0000, LI);
        tbl[22] = mk(T_DIVU,  ALL,             WIDTH'(1),     ALL,            4'b0100, LI);
        tbl[23] = mk(T_REMU,  WIDTH'(1000),    WIDTH'(1000),  '0,             4'b1000, LI);

        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) run_op(tbl[i], 0);

        // Backpressure in DONE, single-cycle and iterative.
        run_op(tbl[0], 5);
        run_op(tbl[6], 5);

        reset_mid_busy();
        run_op(tbl[8], 0);

        rops = '{T_ADD, T_SHL, T_SUB, T_SLT, T_XOR, T_SHR, T_OR, T_AND,
                 T_MUL, T_MULHU, T_DIVU, T_SLTU, T_SRA, T_REMU};
        for (int i = 0; i < 24; i++) begin
            op = rops[$urandom_range(0, 13)];
            a  = rnd();
            b  = rnd();
            if (op == T_DIVU || op == T_REMU) begin
                if ($urandom_range(0, 3) == 0) b = '0;
                else b = b >> $urandom_range(0, WIDTH - 1);
            end
            run_op(model(op, a, b), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
